// File: rtl/jedro_1_dataram_if.sv
// ram_rw_io: jedro-1 data-memory port bundle.
// MASTER is the LSU side, SLAVE the RAM side.
interface ram_rw_io;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport MASTER (
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  modport SLAVE (
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/jedro_1_dataram.sv
// jedro_1_dataram: byte-masked single-port data RAM, no-change read port.
// Range check and error outputs enabled by JEDRO_1_DATARAM_RANGE_CHECK_EN.
module jedro_1_dataram #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ram_rw_io.SLAVE     data_mem_if,
  output logic        err_o,
  output logic [31:0] err_addr_o
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   pipe [READ_LATENCY];
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          is_write;
  logic          unused_bits;

  assign offset      = data_mem_if.addr - BASE_ADDR;
  assign idx         = offset[AW+1:2];
  assign is_write    = |data_mem_if.we;
  assign unused_bits = ^{offset[31:AW+2], offset[1:0]};

`ifdef JEDRO_1_DATARAM_RANGE_CHECK_EN
  assign in_range = offset < SPAN;

  // Flag out-of-range accesses and remember the offending address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      err_addr_o <= 32'h0;
    end else begin
      err_o <= ~in_range;
      if (!in_range) begin
        err_addr_o <= data_mem_if.addr;
      end
    end
  end
`else
  logic [31:0] unused_span;

  assign unused_span = SPAN;
  assign in_range    = 1'b1;
  assign err_o       = 1'b0;
  assign err_addr_o  = 32'h0;
`endif

  // Lane-masked write; dropped during reset or when out of range.
  always_ff @(posedge clk_i) begin
    if (!rst_i && is_write && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_mem_if.we[i]) begin
          mem[idx][8*i +: 8] <= data_mem_if.wdata[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline: stage 0 holds during writes, later stages always shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pipe[i] <= 32'h0;
      end
    end else begin
      if (!is_write) begin
        pipe[0] <= in_range ? mem[idx] : 32'h0;
      end
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign data_mem_if.rdata = pipe[READ_LATENCY-1];
endmodule

// File: tb/tb_jedro_1_dataram.sv
// tb_jedro_1_dataram: table-driven scoreboard bench for jedro_1_dataram.
// Covers both range-check builds and a latency-3 instance.
module tb_jedro_1_dataram;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rst3;
  logic        err;
  logic        err3;
  logic [31:0] ea;
  logic [31:0] ea3;

  ram_rw_io bus ();
  ram_rw_io bus3 ();

  jedro_1_dataram #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0),
    .READ_LATENCY(1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .data_mem_if(bus),
    .err_o      (err),
    .err_addr_o (ea)
  );

  jedro_1_dataram #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0),
    .READ_LATENCY(3)
  ) dut3 (
    .clk_i      (clk),
    .rst_i      (rst3),
    .data_mem_if(bus3),
    .err_o      (err3),
    .err_addr_o (ea3)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic        exp_err;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d);
    bus.addr   = a;
    bus.we     = w;
    bus.wdata  = d;
    bus3.addr  = a;
    bus3.we    = w;
    bus3.wdata = d;
  endtask

  task automatic step(input string nm, input logic [31:0] exp,
                      input logic exp_err);
    sb_t e;
    sb_t p;
    e.name    = nm;
    e.exp     = exp;
    e.exp_err = exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      p = sb_q.pop_front();
      check({p.name, ".rdata"}, bus.rdata, p.exp);
      check({p.name, ".err"}, 32'(err), 32'(p.exp_err));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [18];

  initial begin
    vecs[0]  = '{32'h10, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{32'h10, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{32'h20, 4'hF, 32'h11223344, 32'hDEADBEEF};
    vecs[3]  = '{32'h20, 4'h1, 32'hFFFFFFAA, 32'hDEADBEEF};
    vecs[4]  = '{32'h20, 4'h0, 32'h0,        32'h112233AA};
    vecs[5]  = '{32'h20, 4'h3, 32'hFFFFBBCC, 32'h112233AA};
    vecs[6]  = '{32'h20, 4'h0, 32'h0,        32'h1122BBCC};
    vecs[7]  = '{32'h00, 4'hF, 32'h0000000A, 32'h1122BBCC};
    vecs[8]  = '{32'h04, 4'hF, 32'h0000000B, 32'h1122BBCC};
    vecs[9]  = '{32'h08, 4'hF, 32'h0000000C, 32'h1122BBCC};
    vecs[10] = '{32'h00, 4'h0, 32'h0,        32'h0000000A};
    vecs[11] = '{32'h04, 4'h0, 32'h0,        32'h0000000B};
    vecs[12] = '{32'h08, 4'h0, 32'h0,        32'h0000000C};
    vecs[13] = '{32'h0C, 4'hF, 32'h0000000D, 32'h0000000C};
    vecs[14] = '{32'h0C, 4'h0, 32'h0,        32'h0000000D};
    vecs[15] = '{32'h30, 4'hF, 32'h0,        32'h0000000D};
    vecs[16] = '{32'h30, 4'h6, 32'h12345678, 32'h0000000D};
    vecs[17] = '{32'h33, 4'h0, 32'h0,        32'h00345600};

    rst  = 1'b1;
    rst3 = 1'b1;
    drive(32'h0, 4'h0, 32'h0);
    tick();
    tick();
    check("reset.rdata", bus.rdata, 32'h0);
    check("reset.err", 32'(err), 32'h0);
    check("reset.err_addr", ea, 32'h0);
    check("reset.rdata3", bus3.rdata, 32'h0);
    rst  = 1'b0;
    rst3 = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      step($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
    end

`ifdef JEDRO_1_DATARAM_RANGE_CHECK_EN
    drive(32'h1000, 4'hF, 32'h5);
    step("oor_wr", 32'h00345600, 1'b1);
    check("oor_wr.err_addr", ea, 32'h1000);
    drive(32'h1000, 4'h0, 32'h0);
    step("oor_rd", 32'h0, 1'b1);
    drive(32'h0, 4'h0, 32'h0);
    step("oor_untouched", 32'h0000000A, 1'b0);
    check("oor_hold.err_addr", ea, 32'h1000);
`else
    drive(32'h1000, 4'hF, 32'h5);
    step("alias_wr", 32'h00345600, 1'b0);
    drive(32'h0, 4'h0, 32'h0);
    step("alias_rd", 32'h5, 1'b0);
    check("alias.err_addr", ea, 32'h0);
`endif

    rst  = 1'b1;
    rst3 = 1'b1;
    drive(32'h10, 4'hF, 32'h00000BAD);
    step("rst_wr", 32'h0, 1'b0);
    check("rst_wr.err_addr", ea, 32'h0);
    rst  = 1'b0;
    rst3 = 1'b0;
    drive(32'h10, 4'h0, 32'h0);
    step("rst_wr_dropped", 32'hDEADBEEF, 1'b0);

    drive(32'h10, 4'h0, 32'h0);
    tick();
    rst3 = 1'b1;
    tick();
    check("rl3_rst.rdata", bus3.rdata, 32'h0);
    check("rl3_rst.err", 32'(err3), 32'h0);
    rst3 = 1'b0;
    tick();
    check("rl3_e1.rdata", bus3.rdata, 32'h0);
    tick();
    check("rl3_e2.rdata", bus3.rdata, 32'h0);
    tick();
    check("rl3_e3.rdata", bus3.rdata, 32'hDEADBEEF);

    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
